// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 1/16-scan panel driver: FSM state
// encoding, default geometry and the bit positions of the six colour bits in fb_data.
package hub75_pkg;

  localparam int COLS_DEF = 64;
  localparam int SCAN_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_ADDR,
    ST_DISPLAY
  } state_t;

  localparam int FB_R1 = 5;
  localparam int FB_G1 = 4;
  localparam int FB_B1 = 3;
  localparam int FB_R2 = 2;
  localparam int FB_G2 = 1;
  localparam int FB_B2 = 0;

  // Address fields never collapse to zero width, even with a single plane.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_on_timer.sv
// Display on-time down-counter. Loading sets ON_BASE<<plane-1, so expired_o is
// first seen exactly ON_BASE<<plane cycles after the load edge; it then rests at zero.
module hub75_on_timer
  import hub75_pkg::*;
#(
  parameter int ON_BASE = 8,
  parameter int BPP     = 4,
  parameter int PW      = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [PW-1:0] plane_i,
  output logic          expired_o
);

  localparam int TW = $clog2(ON_BASE << (BPP - 1)) + 1;
  localparam int LW = TW + 1;

  logic [TW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] on_time;

  // The extra bit lets an oversized plane weight be caught instead of wrapping.
  assign on_time   = LW'(ON_BASE) << plane_i;
  assign expired_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = TW'(on_time - LW'(1));
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
    if (!rst_i && load_i) begin
      assert (on_time != '0 && on_time <= LW'(1 << TW));
    end
  end

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 64x32 1/16-scan driver: fetches a row pair from the framebuffer, shifts it out with SCLK,
// latches it, selects ADDR and lights the row. Define HUB75_BCM_EN for BPP-plane binary-coded modulation.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int COLS    = COLS_DEF,
  parameter int SCAN    = SCAN_DEF,
  parameter int BPP     = 4,
  parameter int ON_BASE = 8,
`ifdef HUB75_BCM_EN
  localparam int NPL    = BPP,
`else
  localparam int NPL    = 1,
`endif
  localparam int PW     = clog2_min1(NPL),
  localparam int RW     = $clog2(SCAN),
  localparam int CW     = $clog2(COLS),
  localparam int AW     = PW + RW + CW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  output logic [AW-1:0] fb_addr,
  input  logic [5:0]    fb_data,
  output logic          R1,
  output logic          G1,
  output logic          B1,
  output logic          R2,
  output logic          G2,
  output logic          B2,
  output logic [RW-1:0] ADDR,
  output logic          SCLK,
  output logic          STB,
  output logic          OEb,
  output logic          frame_done
);

  state_t        state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q, addr_q;
  logic [PW-1:0] plane_q, timer_plane;
  logic [5:0]    rgb_q;
  logic          sclk_q, stb_q, oeb_q, frame_done_q;
  logic          timer_exp, last_plane, last_row;

  assign last_plane = (plane_q == PW'(NPL - 1));
  assign last_row   = (row_q == RW'(SCAN - 1));

`ifdef HUB75_BCM_EN
  assign fb_addr     = {plane_q, row_q, col_q};
  assign timer_plane = plane_q;
`else
  assign fb_addr     = {{PW{1'b0}}, row_q, col_q};
  assign timer_plane = '0;
`endif

  hub75_on_timer #(
    .ON_BASE (ON_BASE),
    .BPP     (BPP),
    .PW      (PW)
  ) u_on_timer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (state_q == ST_ADDR),
    .plane_i   (timer_plane),
    .expired_o (timer_exp)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      addr_q       <= '0;
      rgb_q        <= '0;
      sclk_q       <= 1'b0;
      stb_q        <= 1'b0;
      oeb_q        <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      stb_q        <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) state_q <= ST_FETCH;
        end
        ST_FETCH: state_q <= ST_SHIFT_LO;
        // Read data for the current column arrives now; the address already moves on.
        ST_SHIFT_LO: begin
          rgb_q   <= fb_data;
          col_q   <= col_q + 1'b1;
          sclk_q  <= 1'b1;
          state_q <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          sclk_q <= 1'b0;
          // Column address wrapped to zero: the last column was just clocked.
          if (col_q == '0) begin
            stb_q   <= 1'b1;
            state_q <= ST_LATCH;
          end else begin
            state_q <= ST_SHIFT_LO;
          end
        end
        ST_LATCH: begin
          addr_q  <= row_q;
          state_q <= ST_ADDR;
        end
        ST_ADDR: begin
          oeb_q   <= 1'b0;
          state_q <= ST_DISPLAY;
        end
        ST_DISPLAY: begin
          if (timer_exp) begin
            oeb_q <= 1'b1;
            if (last_plane) begin
              plane_q      <= '0;
              row_q        <= last_row ? '0 : row_q + 1'b1;
              frame_done_q <= last_row;
            end else begin
              plane_q <= plane_q + 1'b1;
            end
            state_q <= en ? ST_FETCH : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign R1         = rgb_q[FB_R1];
  assign G1         = rgb_q[FB_G1];
  assign B1         = rgb_q[FB_B1];
  assign R2         = rgb_q[FB_R2];
  assign G2         = rgb_q[FB_G2];
  assign B2         = rgb_q[FB_B2];
  assign ADDR       = addr_q;
  assign SCLK       = sclk_q;
  assign STB        = stb_q;
  assign OEb        = oeb_q;
  assign frame_done = frame_done_q;

endmodule
